regfile_resp: RTL and testbench
===============================

// Module: regfile_resp
// PURPOSE
//  General-purpose register file: the responder end of the operand read interface driven by the
//  decode-stage bypass units (reg_en/reg_addr in, reg_data out). Two read ports, one WB write port.
//  Adds a per-register pending-load scoreboard so decode can stall on load-use hazards beyond EX.
//  Sits between WB (writer) and the two ID-stage bypass instances (readers).
// PARAMETERS
//  NUM_REGS   32            number of architectural registers; entry 0 hardwired to zero
//  ADDR_W     `REG_WIDTH    register index width (5)
//  DATA_W     `DATA_WIDTH   register data width (32)
// PORTS
//  clk        in   1        core clock
//  rst_n      in   1        asynchronous active-low reset
//  r1_en      in   1        read port 1 enable
//  r1_addr    in   ADDR_W   read port 1 index
//  r1_data    out  DATA_W   read port 1 data
//  r1_busy    out  1        read port 1 target has a load in flight
//  r2_en      in   1        read port 2 enable
//  r2_addr    in   ADDR_W   read port 2 index
//  r2_data    out  DATA_W   read port 2 data
//  r2_busy    out  1        read port 2 target has a load in flight
//  wb_en      in   1        WB write enable
//  wb_addr    in   ADDR_W   WB write index
//  wb_data    in   DATA_W   WB write data
//  ld_issue   in   1        ID issues a load this cycle (valid, not stalled)
//  ld_rd      in   ADDR_W   destination of issued load
//  flush      in   1        pipeline flush: drop all pending-load marks
// BEHAVIOUR
//  - Reset (rst_n=0, async): all regs <= 0, busy[] <= 0; outputs read 0 / not busy.
//  - Write: on posedge clk with wb_en && wb_addr!=0, regs[wb_addr] <= wb_data. Writes to r0 ignored.
//  - Read: combinational, zero latency. rN_data = !rN_en ? 0 : rN_addr==0 ? 0 :
//    (wb_en && wb_addr==rN_addr) ? wb_data : regs[rN_addr]  (same-cycle write-through).
//  - Both ports independent; same address on both ports returns identical data.
//  - Scoreboard busy[NUM_REGS], registered, one bit per register, busy[0] constant 0:
//    * set  : ld_issue && ld_rd!=0        -> busy[ld_rd] <= 1 next edge
//    * clear: wb_en && wb_addr!=0         -> busy[wb_addr] <= 0 next edge
//    * same addr set+clear same cycle: set wins (newer load owns the register)
//    * flush: busy <= 0 for all entries; a ld_issue in the same cycle is ignored (flush wins)
//  - rN_busy = rN_en && rN_addr!=0 && busy[rN_addr] && !(wb_en && wb_addr==rN_addr);
//    i.e. a register whose load retires this cycle is reported ready (data via write-through).
//  - No internal stall generation; decode ORs rN_busy with bypass load_flag.
//  - Reset asserted mid-operation: contents and scoreboard cleared immediately; in-flight WB lost.
// CONFIGURATION
//  REGFILE_DIFFTEST_EN defined: adds output dbg_regs [NUM_REGS*DATA_W] (flattened, reg i at
//   bits [i*DATA_W +: DATA_W], entry 0 always 0), showing registered state (no write-through),
//   plus dbg_wb_commit (1 bit) = registered wb_en && wb_addr!=0 from the previous cycle.
//  Not defined: ports absent, no extra logic; functional behaviour identical.
// TESTING
//  T1 reset: rst_n=0 mid-run after writes -> every rN_data=0, rN_busy=0 for all addr 0..31.
//  T2 write/read: wb x5<=32'hDEADBEEF, next cycle r1 addr5 -> 32'hDEADBEEF; r1_en=0 -> 0.
//  T3 r0: wb x0<=32'h1234 then read addr0 both ports -> 0; ld_issue rd=0 -> busy stays 0.
//  T4 write-through: same cycle wb x7<=32'hA5A5A5A5 and r2 addr7 -> r2_data=32'hA5A5A5A5.
//  T5 scoreboard: ld_issue rd=9 -> next cycle r1_busy=1 at addr9; in WB cycle of x9<=32'h42
//     r1_busy=0, r1_data=32'h42; following cycle busy[9]=0.
//  T6 collisions: ld_issue rd=3 with wb x3 same cycle -> busy[3]=1; flush with ld_issue rd=4
//     -> all busy=0 next cycle incl. x4.

Source files
------------

// File: rtl/regfile_resp.sv
// Two-read / one-write register file with a per-register pending-load scoreboard.
// Optional REGFILE_DIFFTEST_EN adds dbg_regs / dbg_wb_commit observation ports.

`ifndef REG_WIDTH
`define REG_WIDTH 5
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module regfile_resp #(
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = `REG_WIDTH,
    parameter int DATA_W   = `DATA_WIDTH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              r1_en,
    input  logic [ADDR_W-1:0] r1_addr,
    output logic [DATA_W-1:0] r1_data,
    output logic              r1_busy,
    input  logic              r2_en,
    input  logic [ADDR_W-1:0] r2_addr,
    output logic [DATA_W-1:0] r2_data,
    output logic              r2_busy,
    input  logic              wb_en,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              ld_issue,
    input  logic [ADDR_W-1:0] ld_rd,
`ifdef REGFILE_DIFFTEST_EN
    input  logic                       flush,
    output logic [NUM_REGS*DATA_W-1:0] dbg_regs,
    output logic                       dbg_wb_commit
`else
    input  logic              flush
`endif
);

    // Interface semantics: rN_en qualifies a read in the same cycle; outputs are
    // combinational and forced to zero / not-busy whenever rN_en is low.

    logic [DATA_W-1:0]   regs [NUM_REGS];
    logic [NUM_REGS-1:0] busy;
    logic                wb_live;
    logic                ld_live;

    assign wb_live = wb_en && (wb_addr != '0);
    assign ld_live = ld_issue && (ld_rd != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wb_live) begin
            regs[wb_addr] <= wb_data;
        end
    end

    // Clear is written before set so a same-register load issue overrides a retiring one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= '0;
        end else if (flush) begin
            busy <= '0;
        end else begin
            if (wb_live) begin
                busy[wb_addr] <= 1'b0;
            end
            if (ld_live) begin
                busy[ld_rd] <= 1'b1;
            end
        end
    end

    always_comb begin
        r1_data = '0;
        r1_busy = 1'b0;
        if (r1_en && (r1_addr != '0)) begin
            if (wb_en && (wb_addr == r1_addr)) begin
                r1_data = wb_data;
            end else begin
                r1_data = regs[r1_addr];
                r1_busy = busy[r1_addr];
            end
        end
    end

    always_comb begin
        r2_data = '0;
        r2_busy = 1'b0;
        if (r2_en && (r2_addr != '0)) begin
            if (wb_en && (wb_addr == r2_addr)) begin
                r2_data = wb_data;
            end else begin
                r2_data = regs[r2_addr];
                r2_busy = busy[r2_addr];
            end
        end
    end

`ifdef REGFILE_DIFFTEST_EN
    // Registered view only: no write-through, entry 0 pinned to zero.
    always_comb begin
        dbg_regs = '0;
        for (int i = 1; i < NUM_REGS; i++) begin
            dbg_regs[i*DATA_W +: DATA_W] = regs[i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dbg_wb_commit <= 1'b0;
        end else begin
            dbg_wb_commit <= wb_live;
        end
    end
`endif

endmodule

// File: tb/tb_regfile_resp.sv
// Directed bench for regfile_resp: driver pushes expected read results, a negedge monitor pops and checks.
`timescale 1ns/1ps

module tb_regfile_resp;
  localparam int AW = 5;
  localparam int DW = 32;
  localparam int NR = 32;
  localparam int W  = 2*DW + 2;

  logic          clk;
  logic          rst_n;
  logic          r1_en, r2_en, wb_en, ld_issue, flush;
  logic [AW-1:0] r1_addr, r2_addr, wb_addr, ld_rd;
  logic [DW-1:0] wb_data, r1_data, r2_data;
  logic          r1_busy, r2_busy;
`ifdef REGFILE_DIFFTEST_EN
  logic [NR*DW-1:0] dbg_regs;
  logic             dbg_wb_commit;
`endif

  logic [W-1:0] exp_q[$];
  string        name_q[$];
  int           checks;
  int           errors;

  regfile_resp #(.NUM_REGS(NR), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .r1_en(r1_en), .r1_addr(r1_addr), .r1_data(r1_data), .r1_busy(r1_busy),
    .r2_en(r2_en), .r2_addr(r2_addr), .r2_data(r2_data), .r2_busy(r2_busy),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .ld_issue(ld_issue), .ld_rd(ld_rd),
`ifdef REGFILE_DIFFTEST_EN
    .flush(flush), .dbg_regs(dbg_regs), .dbg_wb_commit(dbg_wb_commit)
`else
    .flush(flush)
`endif
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver: set inputs for one cycle
  task automatic drive(input logic r1e, input int r1a, input logic r2e, input int r2a,
                       input logic wbe, input int wba, input logic [DW-1:0] wbd,
                       input logic ldi, input int ldr, input logic fl);
    r1_en = r1e;  r1_addr = AW'(r1a);
    r2_en = r2e;  r2_addr = AW'(r2a);
    wb_en = wbe;  wb_addr = AW'(wba);  wb_data = wbd;
    ld_issue = ldi;  ld_rd = AW'(ldr);
    flush = fl;
  endtask

  task automatic expect_rd(input string nm, input logic [DW-1:0] d1, input logic b1,
                           input logic [DW-1:0] d2, input logic b2);
    exp_q.push_back({d1, b1, d2, b2});
    name_q.push_back(nm);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // monitor / scoreboard: outputs are presented combinationally, sampled mid-cycle
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [W-1:0] e;
      logic [W-1:0] got;
      string nm;
      e   = exp_q.pop_front();
      nm  = name_q.pop_front();
      got = {r1_data, r1_busy, r2_data, r2_busy};
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL %s: got r1=%h/%b r2=%h/%b expected r1=%h/%b r2=%h/%b", nm,
                 got[W-1 -: DW], got[DW+1], got[DW:1], got[0],
                 e[W-1 -: DW], e[DW+1], e[DW:1], e[0]);
      end
    end
  end

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step();
    // power-on reset: everything reads zero
    drive(1, 5, 1, 31, 0, 0, 0, 0, 0, 0); expect_rd("por_read", 0, 0, 0, 0);
    step();
    rst_n = 1'b1;

    // T2 write / read / enable gating
    drive(1, 6, 0, 5, 1, 5, 32'hDEADBEEF, 0, 0, 0); expect_rd("t2_wr_cycle", 0, 0, 0, 0);
    step();
    drive(1, 5, 0, 5, 0, 0, 0, 0, 0, 0); expect_rd("t2_read", 32'hDEADBEEF, 0, 0, 0);
    step();
    drive(1, 5, 1, 5, 0, 0, 0, 0, 0, 0); expect_rd("t2_both_ports", 32'hDEADBEEF, 0, 32'hDEADBEEF, 0);
    step();

    // T3 r0 hardwired
    drive(1, 0, 1, 0, 1, 0, 32'h1234, 1, 0, 0); expect_rd("t3_r0_wr_cycle", 0, 0, 0, 0);
    step();
    drive(1, 0, 1, 0, 0, 0, 0, 0, 0, 0); expect_rd("t3_r0_after", 0, 0, 0, 0);
    step();

    // T4 write-through
    drive(1, 7, 1, 7, 1, 7, 32'hA5A5A5A5, 0, 0, 0); expect_rd("t4_through", 32'hA5A5A5A5, 0, 32'hA5A5A5A5, 0);
    step();
    drive(0, 7, 1, 7, 0, 0, 0, 0, 0, 0); expect_rd("t4_stored", 0, 0, 32'hA5A5A5A5, 0);
    step();

    // T5 scoreboard set / retire
    drive(1, 9, 0, 0, 0, 0, 0, 1, 9, 0); expect_rd("t5_issue", 0, 0, 0, 0);
    step();
    drive(1, 9, 0, 9, 0, 0, 0, 0, 0, 0); expect_rd("t5_busy", 0, 1, 0, 0);
    step();
    drive(1, 9, 1, 9, 1, 9, 32'h42, 0, 0, 0); expect_rd("t5_retire", 32'h42, 0, 32'h42, 0);
    step();
    drive(1, 9, 0, 0, 0, 0, 0, 0, 0, 0); expect_rd("t5_cleared", 32'h42, 0, 0, 0);
    step();
    // write to another register leaves a pending mark alone
    drive(0, 0, 0, 0, 0, 0, 0, 1, 11, 0);
    step();
    drive(1, 11, 1, 12, 1, 12, 32'h1, 0, 0, 0); expect_rd("t5_other_wb", 0, 1, 32'h1, 0);
    step();
    drive(1, 11, 1, 12, 0, 0, 0, 0, 0, 0); expect_rd("t5_still_busy", 0, 1, 32'h1, 0);
    step();

    // T6 set+clear collision, then flush beats issue
    drive(1, 3, 0, 0, 1, 3, 32'h33, 1, 3, 0); expect_rd("t6_collide_cycle", 32'h33, 0, 0, 0);
    step();
    drive(1, 3, 1, 11, 0, 0, 0, 0, 0, 0); expect_rd("t6_set_wins", 32'h33, 1, 0, 1);
    step();
    drive(1, 3, 1, 4, 0, 0, 0, 1, 4, 1); expect_rd("t6_flush_cycle", 32'h33, 1, 0, 0);
    step();
    drive(1, 3, 1, 4, 0, 0, 0, 0, 0, 0); expect_rd("t6_flushed_3_4", 32'h33, 0, 0, 0);
    step();
    drive(1, 11, 1, 9, 0, 0, 0, 0, 0, 0); expect_rd("t6_flushed_11", 0, 0, 32'h42, 0);
    step();

    // T1 mid-run reset with a load pending and a WB in flight
    drive(0, 0, 0, 0, 1, 21, 32'h77, 1, 20, 0);
    step();
    drive(1, 21, 1, 20, 0, 0, 0, 0, 0, 0); expect_rd("t1_pre_reset", 32'h77, 0, 0, 1);
    step();
    drive(0, 0, 0, 0, 1, 22, 32'h99, 0, 0, 0);
    #2 rst_n = 1'b0;
    wb_en = 1'b0;
    for (int a = 0; a < NR; a++) begin
      step();
      drive(1, a, 1, NR-1-a, 0, 0, 0, 0, 0, 0);
      expect_rd($sformatf("t1_reset_addr%0d", a), 0, 0, 0, 0);
    end
    step();
    rst_n = 1'b1;
    drive(1, 22, 1, 20, 0, 0, 0, 0, 0, 0); expect_rd("t1_wb_lost", 0, 0, 0, 0);
    step();
    drive(1, 5, 1, 21, 0, 0, 0, 0, 0, 0); expect_rd("t1_after_reset", 0, 0, 0, 0);
    step();

    // drain the scoreboard with a bounded wait
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected responses left, required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
